// File: rtl/cursor_pkg.sv
// Shared types, scan codes and key-mapping helpers for the cursor move controller.
package cursor_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        PFX_IDLE,
        PFX_EXT,
        PFX_BRK,
        PFX_EXT_BRK
    } pfx_state_t;

    localparam logic [BYTE_W-1:0] SC_EXT        = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BRK        = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_P0_UP      = 8'h1D;
    localparam logic [BYTE_W-1:0] SC_P0_DOWN    = 8'h1B;
    localparam logic [BYTE_W-1:0] SC_P0_LEFT    = 8'h1C;
    localparam logic [BYTE_W-1:0] SC_P0_RIGHT   = 8'h23;
    localparam logic [BYTE_W-1:0] SC_P0_CONFIRM = 8'h29;
    localparam logic [BYTE_W-1:0] SC_P1_UP      = 8'h75;
    localparam logic [BYTE_W-1:0] SC_P1_DOWN    = 8'h72;
    localparam logic [BYTE_W-1:0] SC_P1_LEFT    = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_P1_RIGHT   = 8'h74;
    localparam logic [BYTE_W-1:0] SC_P1_CONFIRM = 8'h5A;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic              ext;
        logic              brk;
    } key_evt_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } dir_hit_t;

    // Direction lookup for the given player; P0 keys are normal codes, P1 keys extended.
    function automatic dir_hit_t map_dir(input key_evt_t evt, input logic player);
        dir_hit_t res;
        res.hit = 1'b0;
        res.dir = DIR_UP;
        if (!player && !evt.ext) begin
            case (evt.code)
                SC_P0_UP:    begin res.hit = 1'b1; res.dir = DIR_UP;    end
                SC_P0_DOWN:  begin res.hit = 1'b1; res.dir = DIR_DOWN;  end
                SC_P0_LEFT:  begin res.hit = 1'b1; res.dir = DIR_LEFT;  end
                SC_P0_RIGHT: begin res.hit = 1'b1; res.dir = DIR_RIGHT; end
                default:     res.hit = 1'b0;
            endcase
        end else if (player && evt.ext) begin
            case (evt.code)
                SC_P1_UP:    begin res.hit = 1'b1; res.dir = DIR_UP;    end
                SC_P1_DOWN:  begin res.hit = 1'b1; res.dir = DIR_DOWN;  end
                SC_P1_LEFT:  begin res.hit = 1'b1; res.dir = DIR_LEFT;  end
                SC_P1_RIGHT: begin res.hit = 1'b1; res.dir = DIR_RIGHT; end
                default:     res.hit = 1'b0;
            endcase
        end
        return res;
    endfunction

    // Both confirm keys are normal (non-extended) codes.
    function automatic logic is_confirm(input key_evt_t evt, input logic player);
        return !evt.ext && (evt.code == (player ? SC_P1_CONFIRM : SC_P0_CONFIRM));
    endfunction

endpackage

// File: rtl/cursor_move_ctrl_decoder.sv
// PS/2 set-2 prefix tracker: folds E0/F0 prefixes into a single key event strobe.
module cursor_move_ctrl_decoder
    import cursor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ps2_valid,
    input  logic [BYTE_W-1:0] i_ps2_byte,
    output logic              o_evt_valid_c,
    output key_evt_t          o_evt_c
);

    pfx_state_t r_state;
    pfx_state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= PFX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Event is combinational so the top can register its response one cycle after the final byte.
    always_comb begin
        w_state_nxt   = r_state;
        o_evt_valid_c = 1'b0;
        o_evt_c       = '{code: i_ps2_byte, ext: 1'b0, brk: 1'b0};
        if (i_ps2_valid) begin
            case (r_state)
                PFX_IDLE: begin
                    if (i_ps2_byte == SC_EXT) begin
                        w_state_nxt = PFX_EXT;
                    end else if (i_ps2_byte == SC_BRK) begin
                        w_state_nxt = PFX_BRK;
                    end else begin
                        o_evt_valid_c = 1'b1;
                    end
                end
                PFX_EXT: begin
                    if (i_ps2_byte == SC_BRK) begin
                        w_state_nxt = PFX_EXT_BRK;
                    end else if (i_ps2_byte != SC_EXT) begin
                        o_evt_valid_c = 1'b1;
                        o_evt_c.ext   = 1'b1;
                        w_state_nxt   = PFX_IDLE;
                    end
                end
                PFX_BRK: begin
                    if (i_ps2_byte != SC_BRK) begin
                        o_evt_valid_c = 1'b1;
                        o_evt_c.brk   = 1'b1;
                        w_state_nxt   = PFX_IDLE;
                    end
                end
                PFX_EXT_BRK: begin
                    o_evt_valid_c = 1'b1;
                    o_evt_c.ext   = 1'b1;
                    o_evt_c.brk   = 1'b1;
                    w_state_nxt   = PFX_IDLE;
                end
                default: w_state_nxt = PFX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cursor_move_ctrl.sv
// Turn-arbitrated cursor move sequencer: one step per key press plus timed auto-repeat.
module cursor_move_ctrl
    import cursor_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 12500000,
    parameter int unsigned REPEAT_PERIOD = 2500000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_valid,
    input  logic [BYTE_W-1:0] ps2_byte,
    output logic              mv_valid,
    output logic [1:0]        mv_dir,
    output logic              mv_player,
    output logic              confirm,
    output logic              turn
);

    logic     w_evt_valid;
    key_evt_t w_evt;
    dir_hit_t w_map;
    logic     w_cfm_key;
    logic     w_same_key;

    logic             r_mv_valid, w_mv_valid_nxt;
    dir_t             r_mv_dir, w_mv_dir_nxt;
    logic             r_mv_player, w_mv_player_nxt;
    logic             r_confirm, w_confirm_nxt;
    logic             r_turn, w_turn_nxt;
    logic             r_held_vld, w_held_vld_nxt;
    dir_t             r_held_dir, w_held_dir_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    cursor_move_ctrl_decoder u_decoder (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ps2_valid   (ps2_valid),
        .i_ps2_byte    (ps2_byte),
        .o_evt_valid_c (w_evt_valid),
        .o_evt_c       (w_evt)
    );

    // Only the active player's keys are ever recognised.
    assign w_map      = map_dir(w_evt, r_turn);
    assign w_cfm_key  = is_confirm(w_evt, r_turn);
    assign w_same_key = w_map.hit && r_held_vld && (r_held_dir == w_map.dir);

    // Repeat timer first, then key events override it (a new make or release beats expiry).
    always_comb begin
        w_mv_valid_nxt  = 1'b0;
        w_mv_dir_nxt    = r_mv_dir;
        w_mv_player_nxt = r_mv_player;
        w_confirm_nxt   = 1'b0;
        w_turn_nxt      = r_turn;
        w_held_vld_nxt  = r_held_vld;
        w_held_dir_nxt  = r_held_dir;
        w_cnt_nxt       = r_cnt;

        if (r_held_vld) begin
            if (r_cnt == CNT_W'(1)) begin
                w_mv_valid_nxt  = 1'b1;
                w_mv_dir_nxt    = r_held_dir;
                w_mv_player_nxt = r_turn;
                w_cnt_nxt       = CNT_W'(REPEAT_PERIOD);
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end

        if (w_evt_valid) begin
            if (!w_evt.brk && w_cfm_key) begin
                w_confirm_nxt  = 1'b1;
                w_turn_nxt     = ~r_turn;
                w_held_vld_nxt = 1'b0;
                w_cnt_nxt      = '0;
                w_mv_valid_nxt = 1'b0;
            end else if (!w_evt.brk && w_map.hit && !w_same_key) begin
                w_held_vld_nxt  = 1'b1;
                w_held_dir_nxt  = w_map.dir;
                w_mv_valid_nxt  = 1'b1;
                w_mv_dir_nxt    = w_map.dir;
                w_mv_player_nxt = r_turn;
                w_cnt_nxt       = CNT_W'(REPEAT_DELAY);
            end else if (w_evt.brk && w_same_key) begin
                w_held_vld_nxt = 1'b0;
                w_cnt_nxt      = '0;
                w_mv_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mv_valid  <= 1'b0;
            r_mv_dir    <= DIR_UP;
            r_mv_player <= 1'b0;
            r_confirm   <= 1'b0;
            r_turn      <= 1'b0;
            r_held_vld  <= 1'b0;
            r_held_dir  <= DIR_UP;
            r_cnt       <= '0;
        end else begin
            r_mv_valid  <= w_mv_valid_nxt;
            r_mv_dir    <= w_mv_dir_nxt;
            r_mv_player <= w_mv_player_nxt;
            r_confirm   <= w_confirm_nxt;
            r_turn      <= w_turn_nxt;
            r_held_vld  <= w_held_vld_nxt;
            r_held_dir  <= w_held_dir_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign mv_valid  = r_mv_valid;
    assign mv_dir    = r_mv_dir;
    assign mv_player = r_mv_player;
    assign confirm   = r_confirm;
    assign turn      = r_turn;

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Bench for cursor_move_ctrl: directed scenarios plus random byte streams against a scheduling model.
module tb_cursor_move_ctrl;

    localparam int unsigned DLY = 20;
    localparam int unsigned PER = 5;

    logic       clk;
    logic       rst_n;
    logic       ps2_valid;
    logic [7:0] ps2_byte;
    logic       mv_valid;
    logic [1:0] mv_dir;
    logic       mv_player;
    logic       confirm;
    logic       turn;

    cursor_move_ctrl #(
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER),
        .CNT_W         (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_valid (ps2_valid),
        .ps2_byte  (ps2_byte),
        .mv_valid  (mv_valid),
        .mv_dir    (mv_dir),
        .mv_player (mv_player),
        .confirm   (confirm),
        .turn      (turn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_mv  = 0;

    logic [7:0] p0_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] p1_codes [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] pool     [14] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72,
                                  8'h6B, 8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hF0, 8'h12};

    // Model state: pending prefixes, turn, held key and the absolute cycle of the next repeat.
    bit         m_ext, m_brk, m_turn, m_held;
    logic [7:0] m_held_code;
    int         m_held_dir;
    int         m_next_rep;
    bit         exp_mv, exp_cfm, exp_rst;
    int         exp_dir;
    bit         exp_player;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int key_dir(input logic [7:0] code, input bit ext, input bit player);
        for (int i = 0; i < 4; i++) begin
            if (!player && !ext && code == p0_codes[i]) return i;
            if (player && ext && code == p1_codes[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit v, input logic [7:0] b);
        bit         have, e_ext, e_brk, handled, rep_due;
        logic [7:0] e_code;
        int         d;
        exp_mv  = 0;
        exp_cfm = 0;
        exp_rst = 0;
        if (!rst) begin
            m_ext = 0; m_brk = 0; m_turn = 0; m_held = 0;
            exp_rst = 1; exp_dir = 0; exp_player = 0;
            return;
        end
        have = 0; e_ext = 0; e_brk = 0; e_code = b;
        if (v) begin
            if (m_brk) begin
                if (!(b == 8'hF0 && !m_ext)) begin
                    have = 1; e_ext = m_ext; e_brk = 1;
                    m_ext = 0; m_brk = 0;
                end
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                have = 1; e_ext = m_ext;
                m_ext = 0;
            end
        end
        rep_due = m_held && (cyc == m_next_rep);
        handled = 0;
        if (have) begin
            d = key_dir(e_code, e_ext, m_turn);
            if (!e_brk && !e_ext && e_code == (m_turn ? 8'h5A : 8'h29)) begin
                exp_cfm = 1; m_turn = !m_turn; m_held = 0; handled = 1;
            end else if (!e_brk && d >= 0) begin
                if (!m_held || e_code != m_held_code) begin
                    m_held = 1; m_held_code = e_code; m_held_dir = d;
                    exp_mv = 1; exp_dir = d; exp_player = m_turn;
                    m_next_rep = cyc + DLY;
                    handled = 1;
                end
            end else if (e_brk && d >= 0 && m_held && e_code == m_held_code) begin
                m_held = 0; handled = 1;
            end
        end
        if (!handled && rep_due) begin
            exp_mv = 1; exp_dir = m_held_dir; exp_player = m_turn;
            m_next_rep = cyc + PER;
        end
    endtask

    task automatic tick(input bit r, input bit v, input logic [7:0] b);
        rst_n     = r;
        ps2_valid = v;
        ps2_byte  = b;
        model_step(r, v, b);
        @(posedge clk);
        #1;
        chk("mv_valid", 32'(mv_valid), 32'(exp_mv));
        chk("confirm", 32'(confirm), 32'(exp_cfm));
        chk("turn", 32'(turn), 32'(m_turn));
        if (exp_mv || exp_rst) begin
            chk("mv_dir", 32'(mv_dir), 32'(exp_dir));
            chk("mv_player", 32'(mv_player), 32'(exp_player));
        end
        if (mv_valid) n_mv++;
        cyc++;
        rst_n     = 1'b1;
        ps2_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int mv_base;
        rst_n     = 1'b0;
        ps2_valid = 1'b0;
        ps2_byte  = 8'h00;
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        idle(2);

        // Tap P0 up: exactly one move.
        mv_base = n_mv;
        send(8'h1D); send(8'hF0); send(8'h1D);
        idle(30);
        chk("tap_count", 32'(n_mv - mv_base), 32'd1);

        // Hold P0 right: first move plus repeats at +DLY, +PER, +PER, then release.
        mv_base = n_mv;
        send(8'h23);
        idle(30);
        send(8'hF0); send(8'h23);
        idle(30);
        chk("hold_count", 32'(n_mv - mv_base), 32'd4);

        // P1 key ignored on P0's turn; confirm hands over; P1 key then moves.
        mv_base = n_mv;
        send(8'hE0); send(8'h75);
        idle(3);
        chk("p1_ignored", 32'(n_mv - mv_base), 32'd0);
        send(8'h29);
        idle(2);
        chk("turn_p1", 32'(turn), 32'd1);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(3);
        send(8'h5A);
        idle(2);

        // Held left, switch to down without release, stale left release ignored.
        send(8'h1C);
        idle(7);
        send(8'h1B);
        idle(4);
        send(8'hF0); send(8'h1C);
        idle(30);
        send(8'hF0); send(8'h1B);
        idle(3);

        // New make landing exactly on the repeat-expiry edge.
        mv_base = n_mv;
        send(8'h23);
        idle(DLY - 1);
        send(8'h1B);
        chk("expiry_swap", 32'(n_mv - mv_base), 32'd2);
        idle(3);
        send(8'hF0); send(8'h1B);
        idle(2);

        // Reset between E0 and 75 while P1 is active.
        send(8'h29);
        chk("pre_rst_turn", 32'(turn), 32'd1);
        send(8'hE0);
        tick(1'b0, 1'b0, 8'h00);
        mv_base = n_mv;
        send(8'h75);
        idle(3);
        chk("rst_drop_ext", 32'(n_mv - mv_base), 32'd0);

        // Random byte streams with both turns, holds, typematic repeats and stray resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 79) == 0) begin
                tick(1'b0, 1'b0, 8'h00);
            end else begin
                send(pool[$urandom_range(0, 13)]);
            end
            if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(0, 40)));
            else idle(int'($urandom_range(0, 4)));
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
